instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch unit: FSM state encodings, opcode values
// and the opcode field position within an instruction word.
package instr_fetch_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [2:0] OpDType = 3'b000;
  localparam logic [2:0] OpType1 = 3'b001;
  localparam logic [2:0] OpType2 = 3'b010;

  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 13;

  function automatic logic opcode_legal(input logic [2:0] op);
    return (op == OpDType) || (op == OpType1) || (op == OpType2);
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD sequencer with PC redirect and a one-deep
// instruction hold register. Define FETCH_CNT_EN to add the fetch_count output.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic [15:0] pc_out,
  output logic        illegal,
`ifdef FETCH_CNT_EN
  output logic [15:0] fetch_count,
`endif
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [15:0] target
);

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        redirect;

  assign redirect = jump | branch_taken;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        // A redirect wins over a returning word, which is simply dropped.
        if (redirect) begin
          pc_d = target;
        end else if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = StHold;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          state_d = StReq;
        end else if (instr_ready) begin
          pc_d    = pc_q + 16'd1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      instr_q  <= 16'h0000;
      pc_out_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign opcode      = instr_q[OpcodeMsb:OpcodeLsb];
  assign pc_out      = pc_out_q;
  assign illegal     = instr_valid && !opcode_legal(opcode);

`ifdef FETCH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // A redirect in HOLD with ready high still counts as an accepted instruction.
  assign cnt_d = (instr_valid && instr_ready) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a default instance plus a RESET_PC=16'hFFFF instance
// sharing the same stimulus.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst, imem_ack, instr_ready, jump, branch_taken;
  logic [15:0] imem_rdata, target;

  logic        imem_req, instr_valid, illegal;
  logic [15:0] imem_addr, instr, pc_out;
  logic [2:0]  opcode;
  logic        ff_imem_req, ff_instr_valid, ff_illegal;
  logic [15:0] ff_imem_addr, ff_instr, ff_pc_out;
  logic [2:0]  ff_opcode;
`ifdef FETCH_CNT_EN
  logic [15:0] fetch_count, ff_fetch_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .opcode      (opcode),
    .pc_out      (pc_out),
    .illegal     (illegal),
`ifdef FETCH_CNT_EN
    .fetch_count (fetch_count),
`endif
    .jump        (jump),
    .branch_taken(branch_taken),
    .target      (target)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) dut_ff (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (ff_imem_req),
    .imem_addr   (ff_imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (ff_instr_valid),
    .instr_ready (instr_ready),
    .instr       (ff_instr),
    .opcode      (ff_opcode),
    .pc_out      (ff_pc_out),
    .illegal     (ff_illegal),
`ifdef FETCH_CNT_EN
    .fetch_count (ff_fetch_count),
`endif
    .jump        (jump),
    .branch_taken(branch_taken),
    .target      (target)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    imem_rdata = 16'h0000; target = 16'h0000;
    step();
    step();
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (instr !== 16'h0000) $display("FAIL rst_instr got %h want 0000", instr); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'h0000) $display("FAIL rst_pc_out got %h want 0000", pc_out); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0) $display("FAIL rst_illegal got %b want 0", illegal); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0000) $display("FAIL rst_addr got %h want 0000", imem_addr); else pass_cnt++;
    rst = 1'b0;
    // First cycle after deassertion is still IDLE.
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else pass_cnt++;
    step();
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL req_after_idle got %b want 1", imem_req); else pass_cnt++;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      total_cnt++; if (imem_addr !== 16'(k)) $display("FAIL seq_addr%0d got %h want %h", k, imem_addr, 16'(k)); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b1) $display("FAIL seq_req%0d got %b want 1", k, imem_req); else pass_cnt++;
      imem_ack = 1'b1; imem_rdata = 16'h1000 + 16'(k); instr_ready = 1'b1;
      step();
      imem_ack = 1'b0;
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL seq_valid%0d got %b want 1", k, instr_valid); else pass_cnt++;
      total_cnt++; if (instr !== 16'h1000 + 16'(k)) $display("FAIL seq_instr%0d got %h want %h", k, instr, 16'h1000 + 16'(k)); else pass_cnt++;
      total_cnt++; if (pc_out !== 16'(k)) $display("FAIL seq_pc_out%0d got %h want %h", k, pc_out, 16'(k)); else pass_cnt++;
      step();
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = 16'h4ABC;
    step();
    // Stray acks while holding must be ignored.
    imem_rdata = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      total_cnt++; if (instr !== 16'h4ABC) $display("FAIL stall_instr%0d got %h want 4abc", c, instr); else pass_cnt++;
      total_cnt++; if (pc_out !== 16'h0004) $display("FAIL stall_pc_out%0d got %h want 0004", c, pc_out); else pass_cnt++;
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL stall_valid%0d got %b want 1", c, instr_valid); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL stall_req%0d got %b want 0", c, imem_req); else pass_cnt++;
      total_cnt++; if (illegal !== 1'b0) $display("FAIL stall_illegal%0d got %b want 0", c, illegal); else pass_cnt++;
      step();
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL stall_release_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0005) $display("FAIL stall_next_addr got %h want 0005", imem_addr); else pass_cnt++;
  endtask

  task automatic test_jump_ack();
    jump = 1'b1; target = 16'h0040; imem_ack = 1'b1; imem_rdata = 16'h2222;
    step();
    jump = 1'b0; imem_ack = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL jump_discard_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL jump_req got %b want 1", imem_req); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0040) $display("FAIL jump_addr got %h want 0040", imem_addr); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 16'h3333;
    step();
    imem_ack = 1'b0;
    total_cnt++; if (instr !== 16'h3333) $display("FAIL jump_fetch_instr got %h want 3333", instr); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'h0040) $display("FAIL jump_fetch_pc got %h want 0040", pc_out); else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    // Redirect in HOLD without acceptance.
    jump = 1'b1; target = 16'h0080;
    step();
    jump = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL hold_jump_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0080) $display("FAIL hold_jump_addr got %h want 0080", imem_addr); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 16'h2001;
    step();
    imem_ack = 1'b0;
    total_cnt++; if (pc_out !== 16'h0080) $display("FAIL hold_fetch_pc got %h want 0080", pc_out); else pass_cnt++;
    // Branch coincident with acceptance.
    branch_taken = 1'b1; target = 16'h0100; instr_ready = 1'b1;
    step();
    branch_taken = 1'b0; instr_ready = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL br_accept_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0100) $display("FAIL br_accept_addr got %h want 0100", imem_addr); else pass_cnt++;
`ifdef FETCH_CNT_EN
    total_cnt++; if (fetch_count !== 16'd6) $display("FAIL fetch_count got %0d want 6", fetch_count); else pass_cnt++;
`endif
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    total_cnt++; if (ff_imem_addr !== 16'hFFFF) $display("FAIL wrap_reset_pc got %h want ffff", ff_imem_addr); else pass_cnt++;
    imem_ack = 1'b1; imem_rdata = 16'hA000;
    step();
    imem_ack = 1'b0;
    total_cnt++; if (ff_pc_out !== 16'hFFFF) $display("FAIL wrap_pc_out got %h want ffff", ff_pc_out); else pass_cnt++;
    total_cnt++; if (ff_opcode !== 3'b101) $display("FAIL wrap_opcode got %b want 101", ff_opcode); else pass_cnt++;
    total_cnt++; if (ff_illegal !== 1'b1) $display("FAIL wrap_illegal got %b want 1", ff_illegal); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b1) $display("FAIL illegal_default got %b want 1", illegal); else pass_cnt++;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total_cnt++; if (ff_imem_addr !== 16'h0000) $display("FAIL wrap_next_addr got %h want 0000", ff_imem_addr); else pass_cnt++;
    total_cnt++; if (ff_illegal !== 1'b0) $display("FAIL wrap_illegal_drop got %b want 0", ff_illegal); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    total_cnt++; if (imem_req !== 1'b1) $display("FAIL mid_pre_req got %b want 1", imem_req); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h5555;
    step();
    imem_ack = 1'b0;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (imem_addr !== 16'h0000) $display("FAIL mid_addr got %h want 0000", imem_addr); else pass_cnt++;
    step();
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL mid_valid_later got %b want 0", instr_valid); else pass_cnt++;
    total_cnt++; if (instr !== 16'h0000) $display("FAIL mid_instr got %h want 0000", instr); else pass_cnt++;
`ifdef FETCH_CNT_EN
    total_cnt++; if (fetch_count !== 16'd0) $display("FAIL mid_fetch_count got %0d want 0", fetch_count); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump_ack();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
